// File: rtl/cpu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_ctrl_pkg
//  Brief    : Shared encodings, widths and defaults for the CPU step
//             controller and its input debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_step_ctrl_pkg;

  // Instruction / address width of the RV32I core
  localparam int INSTRUCTION_SIZE = 32;

  // Controller state register width and encodings (3 is illegal)
  localparam int CTRL_STATE_W = 2;

  typedef enum logic [CTRL_STATE_W-1:0] {
    CTRL_STEP  = 2'd0,
    CTRL_RUN   = 2'd1,
    CTRL_BREAK = 2'd2
  } ctrl_state_t;

  // Board defaults at 100 MHz: 10 ms debounce, 10 Hz run rate
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_RUN_PERIOD      = 10_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
//  Module   : debounce
//  Brief    : 2-FF synchronizer followed by a stable-count debouncer. The
//             output level follows the synchronized input only after the two
//             have differed for DEBOUNCE_CYCLES consecutive cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int              c_CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [c_CW-1:0] r_cnt;

  // Two-stage synchronizer for the asynchronous raw input
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreement restarts the count
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == c_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + c_CW'(1);
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_ctrl
//  Brief    : Execution controller producing a one-cycle CPU clock-enable
//             for free-running, single-step and break-on-PC operation.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RUN_PERIOD      = DEFAULT_RUN_PERIOD
) (
  input  logic                        clk100MHz,
  input  logic                        rst,
  input  logic                        btn_step,
  input  logic                        sw_run,
  input  logic                        bp_en,
  input  logic [INSTRUCTION_SIZE-1:0] bp_addr,
  input  logic [INSTRUCTION_SIZE-1:0] pc_in,
  output logic                        cpu_ce,
  output logic [CTRL_STATE_W-1:0]     state,
  output logic                        halted,
  output logic [INSTRUCTION_SIZE-1:0] step_count
);

  localparam int              c_RW   = cnt_width(RUN_PERIOD);
  localparam logic [c_RW-1:0] c_TERM = c_RW'(RUN_PERIOD - 1);

  logic                        w_btn_db;
  logic                        w_run_db;
  logic                        r_btn_prev;
  logic                        r_step_edge;
  logic [c_RW-1:0]             r_run_cnt;
  logic                        w_terminal;
  logic                        w_bp_hit;
  ctrl_state_t                 r_state;
  ctrl_state_t                 w_next_state;
  logic                        w_fire;
  logic                        r_cpu_ce;
  logic                        r_halted;
  logic [INSTRUCTION_SIZE-1:0] r_step_count;

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_step (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .i_raw     (btn_step),
    .o_level   (w_btn_db)
  );

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_run (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .i_raw     (sw_run),
    .o_level   (w_run_db)
  );

  // Registered rising-edge detector on the debounced step button
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_btn_prev  <= 1'b0;
      r_step_edge <= 1'b0;
    end else begin
      r_btn_prev  <= w_btn_db;
      r_step_edge <= w_btn_db & ~r_btn_prev;
    end
  end

  // Run-rate counter: held at zero outside RUN so every RUN entry starts fresh
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (r_state != CTRL_RUN || w_terminal) begin
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= r_run_cnt + c_RW'(1);
    end
  end

  assign w_terminal = (r_run_cnt == c_TERM);
  assign w_bp_hit   = bp_en && (pc_in == bp_addr);

  // State register with the enable, halted flag and pulse counter alongside
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_state      <= CTRL_STEP;
      r_halted     <= 1'b0;
      r_cpu_ce     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == CTRL_BREAK);
      r_cpu_ce <= w_fire;
      if (w_fire) begin
        r_step_count <= r_step_count + INSTRUCTION_SIZE'(1);
      end
    end
  end

  // Next-state and pulse decision; the mode switch dropping in RUN wins over
  // the terminal count, and a breakpoint hit suppresses the pulse
  always_comb begin
    w_next_state = r_state;
    w_fire       = 1'b0;
    case (r_state)
      CTRL_STEP: begin
        if (r_step_edge) begin
          w_fire = 1'b1;
        end
        if (w_run_db) begin
          w_next_state = CTRL_RUN;
        end
      end
      CTRL_RUN: begin
        if (!w_run_db) begin
          w_next_state = CTRL_STEP;
        end else if (w_terminal) begin
          if (w_bp_hit) begin
            w_next_state = CTRL_BREAK;
          end else begin
            w_fire = 1'b1;
          end
        end
      end
      CTRL_BREAK: begin
        if (r_step_edge) begin
          w_fire       = 1'b1;
          w_next_state = w_run_db ? CTRL_RUN : CTRL_STEP;
        end else if (!w_run_db) begin
          w_next_state = CTRL_STEP;
        end
      end
      default: begin
        w_next_state = CTRL_STEP;
      end
    endcase
  end

  assign cpu_ce     = r_cpu_ce;
  assign state      = r_state;
  assign halted     = r_halted;
  assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_step_ctrl
//  Brief    : Scoreboard bench for cpu_step_ctrl with short debounce and run
//             periods; expected pulses are queued by stimulus and retired by
//             an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

  localparam int c_DB  = 4;
  localparam int c_RP  = 8;
  localparam int c_LAT = c_DB + 4;

  logic        clk100MHz = 1'b0;
  logic        rst       = 1'b0;
  logic        btn_step  = 1'b0;
  logic        sw_run    = 1'b0;
  logic        bp_en     = 1'b0;
  logic [31:0] bp_addr   = 32'h0;
  logic [31:0] pc_in     = 32'h0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] step_count;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (c_DB),
    .RUN_PERIOD      (c_RP)
  ) dut (
    .clk100MHz  (clk100MHz),
    .rst        (rst),
    .btn_step   (btn_step),
    .sw_run     (sw_run),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_in      (pc_in),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .halted     (halted),
    .step_count (step_count)
  );

  always #5 clk100MHz = ~clk100MHz;

  // Count rising edges so pulse timing can be checked in absolute cycles
  always @(posedge clk100MHz) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk100MHz) begin : mon
    exp_t e;
    if (!rst && cpu_ce) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: cpu_ce high at cycle %0d step_count=%h, none expected",
                 cyc, step_count);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.cnt !== step_count) begin
          bad++;
          $display("FAIL pulse: got cycle=%0d count=%h, expected cycle=%0d count=%h",
                   cyc, step_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [31:0] cnt);
    exp_t e;
    e.cyc = at;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk100MHz);
      if (state == s) begin
        at = cyc;
        break;
      end
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL wait_state_%0d: timeout after %0d cycles, got state=%0d", s, limit, state);
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk100MHz);
  endtask

  // Clean press from a negedge: pulse expected c_LAT edges later
  task automatic press(input logic [31:0] cnt);
    expect_pulse(cyc + c_LAT, cnt);
    btn_step = 1'b1;
    repeat (c_LAT + 2) @(negedge clk100MHz);
    btn_step = 1'b0;
    repeat (12) @(negedge clk100MHz);
  endtask

  initial begin
    int t;
    int n;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_step_count", step_count, 32'd0);
    repeat (3) @(negedge clk100MHz);
    rst = 1'b0;
    repeat (100) @(negedge clk100MHz);
    check("idle_state", {30'b0, state}, 32'd0);
    check("idle_step_count", step_count, 32'd0);

    // Bounce rejection then a held press
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1;
      repeat (2) @(negedge clk100MHz);
      btn_step = 1'b0;
      repeat (2) @(negedge clk100MHz);
    end
    press(32'd1);
    check("bounce_step_count", step_count, 32'd1);

    // Run mode: five pulses spaced RUN_PERIOD apart
    sw_run = 1'b1;
    wait_state(2'd1, 20, t);
    for (int k = 1; k <= 5; k++) expect_pulse(t + k * c_RP, 32'(1 + k));
    wait_cycle(t + 5 * c_RP);
    check("run_step_count", step_count, 32'd6);

    // Switch falls on the terminal-count cycle of the sixth pulse
    wait_cycle(t + 5 * c_RP + 1);
    sw_run = 1'b0;
    wait_cycle(t + 6 * c_RP);
    check("exit_prio_state", {30'b0, state}, 32'd0);
    repeat (10) @(negedge clk100MHz);
    check("exit_prio_count", step_count, 32'd6);

    // Breakpoint on the first terminal count after RUN entry
    bp_addr = 32'h0000_0010;
    pc_in   = 32'h0000_0010;
    bp_en   = 1'b1;
    sw_run  = 1'b1;
    wait_state(2'd1, 20, t);
    wait_state(2'd2, 20, n);
    check("break_cycle", 32'(n), 32'(t + c_RP));
    check("break_halted", {31'b0, halted}, 32'd1);
    check("break_count", step_count, 32'd6);
    n = cyc;
    expect_pulse(n + c_LAT, 32'd7);
    btn_step = 1'b1;
    wait_cycle(n + c_LAT);
    check("break_step_state", {30'b0, state}, 32'd1);
    check("break_step_halted", {31'b0, halted}, 32'd0);
    btn_step = 1'b0;
    sw_run   = 1'b0;
    wait_state(2'd0, 20, t);
    bp_en = 1'b0;
    repeat (12) @(negedge clk100MHz);

    // Counter wrap
    force dut.r_step_count = 32'hFFFF_FFFF;
    @(negedge clk100MHz);
    release dut.r_step_count;
    @(negedge clk100MHz);
    check("wrap_preset", step_count, 32'hFFFF_FFFF);
    press(32'd0);
    check("wrap_count", step_count, 32'd0);

    // Asynchronous reset mid-RUN, landing on a pending pulse cycle
    sw_run = 1'b1;
    wait_state(2'd1, 20, t);
    expect_pulse(t + c_RP, 32'd1);
    wait_cycle(t + 2 * c_RP - 1);
    @(posedge clk100MHz);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("async_rst_state", {30'b0, state}, 32'd0);
    check("async_rst_count", step_count, 32'd0);
    sw_run = 1'b0;
    repeat (5) @(negedge clk100MHz);
    rst = 1'b0;
    repeat (30) @(negedge clk100MHz);
    check("post_rst_state", {30'b0, state}, 32'd0);
    check("post_rst_count", step_count, 32'd0);
    check("pending_pulses", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
